// File: rtl/compute_arbiter.sv
// Round-robin arbiter that lets UNIT_COUNT processing units share one compute unit.
// Sequences the request/ready/done handshake, routes the result back, and aborts on timeout.
module compute_arbiter #(
    parameter int UNIT_COUNT = 4,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic [UNIT_COUNT-1:0]            req,
    input  logic [UNIT_COUNT*OP_WIDTH-1:0]   req_op,
    input  logic [UNIT_COUNT*DATA_WIDTH-1:0] req_data,
    output logic [UNIT_COUNT-1:0]            grant,
    output logic [UNIT_COUNT-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_data,
    output logic                             resp_error,
    output logic                             cu_request,
    output logic [OP_WIDTH-1:0]              cu_op,
    output logic [DATA_WIDTH-1:0]            cu_data,
    input  logic                             cu_ready,
    input  logic                             cu_done,
    input  logic [DATA_WIDTH-1:0]            cu_result,
    output logic                             busy,
    output logic [15:0]                      grant_count,
    output logic [7:0]                       timeout_count,
    output logic [1:0]                       state_dbg
);

    localparam int IDX_W = (UNIT_COUNT > 1) ? $clog2(UNIT_COUNT) : 1;
    localparam logic [UNIT_COUNT-1:0] ONE_HOT_0 = {{(UNIT_COUNT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [IDX_W-1:0]        winner_q, winner_d;
    logic [OP_WIDTH-1:0]     op_q, op_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [7:0]              tmo_q, tmo_d;
    logic [UNIT_COUNT-1:0]   grant_q, grant_d;
    logic [UNIT_COUNT-1:0]   resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic                    resp_error_q, resp_error_d;
    logic                    cu_request_q, cu_request_d;
    logic [OP_WIDTH-1:0]     cu_op_q, cu_op_d;
    logic [DATA_WIDTH-1:0]   cu_data_q, cu_data_d;
    logic                    busy_q, busy_d;
    logic [15:0]             grant_count_q, grant_count_d;
    logic [7:0]              timeout_count_q, timeout_count_d;

    logic                    sel_found;
    logic [IDX_W-1:0]        sel_idx;

    // Rotating priority: first requester strictly after the last winner.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < UNIT_COUNT; i++) begin
            if (!sel_found && req[(int'(last_grant_q) + 1 + i) % UNIT_COUNT]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((int'(last_grant_q) + 1 + i) % UNIT_COUNT);
            end
        end
    end

    // Outputs are computed from the next state so every output is a flop.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        winner_d        = winner_q;
        op_d            = op_q;
        data_d          = data_q;
        tmo_d           = tmo_q;
        grant_d         = '0;
        resp_valid_d    = '0;
        resp_data_d     = '0;
        resp_error_d    = 1'b0;
        cu_request_d    = 1'b0;
        cu_op_d         = '0;
        cu_data_d       = '0;
        grant_count_d   = grant_count_q;
        timeout_count_d = timeout_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable && sel_found) begin
                    state_d       = S_ISSUE;
                    winner_d      = sel_idx;
                    last_grant_d  = sel_idx;
                    op_d          = req_op[sel_idx*OP_WIDTH +: OP_WIDTH];
                    data_d        = req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                    tmo_d         = 8'd0;
                    grant_d       = ONE_HOT_0 << sel_idx;
                    cu_request_d  = 1'b1;
                    cu_op_d       = req_op[sel_idx*OP_WIDTH +: OP_WIDTH];
                    cu_data_d     = req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                    grant_count_d = (grant_count_q == 16'hFFFF) ? grant_count_q
                                                                : grant_count_q + 16'd1;
                end
            end
            S_ISSUE: begin
                tmo_d = tmo_q + 8'd1;
                // Timeout must win here, otherwise WAIT would start past the limit.
                if (tmo_q == 8'(TIMEOUT)) begin
                    state_d      = S_RESPOND;
                    resp_error_d = 1'b1;
                end else if (cu_ready) begin
                    state_d = S_WAIT;
                end else begin
                    cu_request_d = 1'b1;
                    cu_op_d      = op_q;
                    cu_data_d    = data_q;
                end
            end
            S_WAIT: begin
                tmo_d = tmo_q + 8'd1;
                if (cu_done) begin
                    state_d     = S_RESPOND;
                    resp_data_d = cu_result;
                end else if (tmo_q == 8'(TIMEOUT)) begin
                    state_d      = S_RESPOND;
                    resp_error_d = 1'b1;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_RESPOND && state_d == S_RESPOND) begin
            resp_valid_d = ONE_HOT_0 << winner_q;
            if (resp_error_d) begin
                timeout_count_d = (timeout_count_q == 8'hFF) ? timeout_count_q
                                                             : timeout_count_q + 8'd1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            last_grant_q    <= IDX_W'(UNIT_COUNT - 1);
            winner_q        <= '0;
            op_q            <= '0;
            data_q          <= '0;
            tmo_q           <= '0;
            grant_q         <= '0;
            resp_valid_q    <= '0;
            resp_data_q     <= '0;
            resp_error_q    <= 1'b0;
            cu_request_q    <= 1'b0;
            cu_op_q         <= '0;
            cu_data_q       <= '0;
            busy_q          <= 1'b0;
            grant_count_q   <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            winner_q        <= winner_d;
            op_q            <= op_d;
            data_q          <= data_d;
            tmo_q           <= tmo_d;
            grant_q         <= grant_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_error_q    <= resp_error_d;
            cu_request_q    <= cu_request_d;
            cu_op_q         <= cu_op_d;
            cu_data_q       <= cu_data_d;
            busy_q          <= busy_d;
            grant_count_q   <= grant_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign grant         = grant_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_error    = resp_error_q;
    assign cu_request    = cu_request_q;
    assign cu_op         = cu_op_q;
    assign cu_data       = cu_data_q;
    assign busy          = busy_q;
    assign grant_count   = grant_count_q;
    assign timeout_count = timeout_count_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_compute_arbiter.sv
// Directed bench for compute_arbiter: 4 units, TIMEOUT=8, hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_compute_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int OW = 2;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic [N-1:0]    req;
    logic [N*OW-1:0] req_op;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    grant;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;
    logic            resp_error;
    logic            cu_request;
    logic [OW-1:0]   cu_op;
    logic [DW-1:0]   cu_data;
    logic            cu_ready;
    logic            cu_done;
    logic [DW-1:0]   cu_result;
    logic            busy;
    logic [15:0]     grant_count;
    logic [7:0]      timeout_count;
    logic [1:0]      state_dbg;

    int tests_run;
    int tests_failed;

    compute_arbiter #(
        .UNIT_COUNT(N), .DATA_WIDTH(DW), .OP_WIDTH(OW), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req(req), .req_op(req_op), .req_data(req_data),
        .grant(grant), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_error(resp_error), .cu_request(cu_request), .cu_op(cu_op),
        .cu_data(cu_data), .cu_ready(cu_ready), .cu_done(cu_done),
        .cu_result(cu_result), .busy(busy), .grant_count(grant_count),
        .timeout_count(timeout_count), .state_dbg(state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction with immediate ready then done; the granted unit drops req.
    task automatic txn(input logic [N-1:0] r, input logic [N-1:0] exp_g, input logic [31:0] res);
        req = r;
        tick();
        check("txn_grant", 32'(grant), 32'(exp_g));
        req      = r & ~exp_g;
        cu_ready = 1'b1;
        tick();
        cu_ready  = 1'b0;
        cu_done   = 1'b1;
        cu_result = res;
        tick();
        check("txn_resp_valid", 32'(resp_valid), 32'(exp_g));
        check("txn_resp_data", resp_data, res);
        check("txn_resp_error", 32'(resp_error), 32'h0);
        cu_done = 1'b0;
        req     = '0;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [N-1:0] rr_exp [5];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        enable    = 1'b1;
        req       = '0;
        req_op    = '0;
        req_data  = '0;
        cu_ready  = 1'b0;
        cu_done   = 1'b0;
        cu_result = '0;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cu_request", 32'(cu_request), 32'h0);
        check("rst_grant_count", 32'(grant_count), 32'h0);
        check("rst_timeout_count", 32'(timeout_count), 32'h0);
        check("rst_state", 32'(state_dbg), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single request from unit 0.
        req               = 4'b0001;
        req_op[1:0]       = 2'd2;
        req_data[31:0]    = 32'h1234;
        req_op[7:6]       = 2'd1;
        req_data[127:96]  = 32'hAAAA;
        tick();
        check("s_grant", 32'(grant), 32'h1);
        check("s_cu_request", 32'(cu_request), 32'h1);
        check("s_cu_op", 32'(cu_op), 32'h2);
        check("s_cu_data", cu_data, 32'h1234);
        check("s_busy", 32'(busy), 32'h1);
        req      = '0;
        cu_ready = 1'b1;
        tick();
        check("s_grant_pulse", 32'(grant), 32'h0);
        check("s_cu_request_drop", 32'(cu_request), 32'h0);
        check("s_cu_data_idle", cu_data, 32'h0);
        cu_ready  = 1'b0;
        cu_done   = 1'b1;
        cu_result = 32'h5678;
        tick();
        check("s_resp_valid", 32'(resp_valid), 32'h1);
        check("s_resp_data", resp_data, 32'h5678);
        check("s_resp_error", 32'(resp_error), 32'h0);
        check("s_grant_count", 32'(grant_count), 32'h1);
        cu_done = 1'b0;
        tick();
        check("s_resp_pulse", 32'(resp_valid), 32'h0);
        check("s_resp_data_zero", resp_data, 32'h0);
        check("s_busy_idle", 32'(busy), 32'h0);

        // Restart so unit 0 has first priority, then all units request continuously.
        do_reset();
        check("rr_count_cleared", 32'(grant_count), 32'h0);
        req      = 4'b1111;
        cu_ready = 1'b1;
        cu_done  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cu_result = 32'h100 + 32'(k);
            tick();
            check("rr_grant", 32'(grant), 32'(rr_exp[k]));
            tick();
            tick();
            check("rr_resp_valid", 32'(resp_valid), 32'(rr_exp[k]));
            check("rr_resp_data", resp_data, 32'h100 + 32'(k));
            if (k == 4) req = '0;
            tick();
        end
        cu_ready = 1'b0;
        cu_done  = 1'b0;
        check("rr_grant_count", 32'(grant_count), 32'd5);

        // Unit 1 last granted, then 1010 -> unit 3 first, then unit 1.
        txn(4'b0010, 4'b0010, 32'h11);
        txn(4'b1010, 4'b1000, 32'h33);
        txn(4'b0010, 4'b0010, 32'h22);
        check("pri_grant_count", 32'(grant_count), 32'd8);

        // Hung compute unit: ready but never done.
        req       = 4'b0001;
        cu_result = 32'hDEAD;
        tick();
        check("to_grant", 32'(grant), 32'h1);
        req      = '0;
        cu_ready = 1'b1;
        tick();
        cu_ready = 1'b0;
        for (int k = 2; k <= 8; k++) tick();
        check("to_no_resp_early", 32'(resp_valid), 32'h0);
        check("to_busy", 32'(busy), 32'h1);
        tick();
        check("to_resp_valid", 32'(resp_valid), 32'h1);
        check("to_resp_error", 32'(resp_error), 32'h1);
        check("to_resp_data", resp_data, 32'h0);
        check("to_count", 32'(timeout_count), 32'h1);
        tick();
        check("to_error_clear", 32'(resp_error), 32'h0);
        txn(4'b0100, 4'b0100, 32'hABC);
        check("to_count_hold", 32'(timeout_count), 32'h1);

        // Enable dropped while WAIT with unit 2 pending.
        req = 4'b0001;
        tick();
        check("en_grant", 32'(grant), 32'h1);
        req      = 4'b0100;
        cu_ready = 1'b1;
        tick();
        enable    = 1'b0;
        cu_ready  = 1'b0;
        cu_done   = 1'b1;
        cu_result = 32'h77;
        tick();
        check("en_resp_valid", 32'(resp_valid), 32'h1);
        check("en_resp_data", resp_data, 32'h77);
        cu_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("en_no_grant", 32'(grant), 32'h0);
            check("en_idle", 32'(busy), 32'h0);
        end
        enable = 1'b1;
        tick();
        check("en_resume_grant", 32'(grant), 32'h4);
        req      = '0;
        cu_ready = 1'b1;
        tick();
        cu_ready  = 1'b0;
        cu_done   = 1'b1;
        cu_result = 32'h99;
        tick();
        check("en_resume_resp", 32'(resp_valid), 32'h4);
        cu_done = 1'b0;
        tick();
        check("en_grant_count", 32'(grant_count), 32'd12);

        // Reset asserted in WAIT aborts the transaction immediately.
        req = 4'b0010;
        tick();
        check("rw_grant", 32'(grant), 32'h2);
        req      = '0;
        cu_ready = 1'b1;
        tick();
        cu_ready = 1'b0;
        check("rw_busy_wait", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rw_busy_async", 32'(busy), 32'h0);
        check("rw_cu_request_async", 32'(cu_request), 32'h0);
        check("rw_grant_count_async", 32'(grant_count), 32'h0);
        cu_done   = 1'b1;
        cu_result = 32'h55;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rw_no_resp", 32'(resp_valid), 32'h0);
        end
        cu_done = 1'b0;
        req     = 4'b1111;
        tick();
        check("rw_grant_unit0", 32'(grant), 32'h1);
        req = '0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
